timer_key_ctrl: RTL and testbench
=================================

# timer_key_ctrl

Front-panel controller for the 60 s timer datapath. It synchronises and debounces four raw push-buttons and runs a mode state machine. It sequences the timer core by driving its `en`, `pause`, `key0`/`key1`/`key4`/`key5` pulses and the `ten`/`one` preset. It sits between the board buttons and the `timer_60s` top, replacing direct button wiring.

## Interface
- `DEBOUNCE_CYCLES`, default 4 (sim); 1,000,000 on board. Number of consecutive stable synchronised samples needed to accept a level change. Must be ≥ 2.
- `clk_50M`  in  1  system clock, 50 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `key_raw`  in  4  raw buttons, active-low: [0] START, [1] MODE, [2] SET, [3] FREQ
- `cnt_zero`  in  1  timer core reports 00.0 while counting down (level)
- `en`  out  1  timer enable (level)
- `pause`  out  1  timer pause (level)
- `key0`  out  1  start count-up, 1-cycle pulse
- `key1`  out  1  start count-down, 1-cycle pulse
- `key4`  out  1  pause/resume toggle, 1-cycle pulse
- `key5`  out  1  frequency step, 1-cycle pulse
- `ten`  out  4  preset tens, BCD 0–5
- `one`  out  4  preset ones, BCD 0–9
- `dir_down`  out  1  selected direction: 0 = up, 1 = down
- `done_led`  out  1  high in DONE
- `state_o`  out  3  current state encoding, for debug

## Operation
- **Key path, per key:**
  - 2-FF synchroniser, then debounce counter.
  - The counter clears whenever the synchronised level equals the stable level.
  - Otherwise it increments. At `DEBOUNCE_CYCLES` the stable level flips and the counter clears.
  - A press event (stable 1→0) produces one internal pulse. Releases produce nothing.
- **Priority within a cycle:** only one FSM event is accepted per cycle, in the order START > MODE > SET. Lower-priority pulses in the same cycle are dropped. FREQ is independent and is forwarded as `key5` in every state.
- **States:** IDLE, SET_TEN, SET_ONE, RUN_UP, RUN_DOWN, PAUSED, DONE.
- **IDLE:**
  - MODE toggles `dir_down`.
  - SET → SET_TEN.
  - START with dir up → RUN_UP and pulse `key0`.
  - START with dir down and preset ≠ 00 → RUN_DOWN and pulse `key1`.
  - START with dir down and preset = 00 is ignored.
- **SET_TEN:** SET increments `ten` modulo 6 (5→0). MODE → SET_ONE. START → IDLE.
- **SET_ONE:** SET increments `one` modulo 10 (9→0). MODE → IDLE. START → IDLE.
- **RUN_UP / RUN_DOWN:** START → PAUSED and pulse `key4`; the prior run state is remembered. In RUN_DOWN, `cnt_zero`=1 → DONE, and this overrides a same-cycle START.
- **PAUSED:** START → remembered run state and pulse `key4`. MODE → IDLE (abort). SET is ignored.
- **DONE:** any START or MODE → IDLE.
- **Output levels:**
  - `en`=1 in RUN_UP, RUN_DOWN and PAUSED; otherwise 0.
  - `pause`=1 only in PAUSED.
  - `ten`/`one` hold in all states except SET_*.
- **Reset values:** state IDLE. `dir_down`=0, `ten`=0, `one`=0. All pulse outputs, `en`, `pause` and `done_led` are 0. Debounce stable levels are 1 (released) and counters are 0.

## Timing
- Raw press held low from clock edge N → internal press pulse at edge N+2+`DEBOUNCE_CYCLES`.
- The FSM registers the transition and its output pulse one edge later, so the total is 3+`DEBOUNCE_CYCLES` edges.
- Bounce shorter than `DEBOUNCE_CYCLES` samples produces no pulse. The key must be released (stable high) before a second press is accepted.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `cnt_zero` is sampled directly, with no synchronisation, because it comes from the same clock domain. DONE is entered on the next edge.
- Reset assertion mid-operation clears everything asynchronously. The first accepted press after deassertion follows the latency above.

## Structure
- `timer_ctrl_pkg` holds:
  - the state enum (3-bit);
  - key index constants KEY_START=0, KEY_MODE=1, KEY_SET=2, KEY_FREQ=3;
  - BCD limits TEN_MAX=5 and ONE_MAX=9.
- Sub-module `key_debounce` contains the synchroniser, the counter and the press-pulse logic, parameterised by `DEBOUNCE_CYCLES`. It is instantiated four times.
- The FSM and preset registers live in `timer_key_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Debounce:** a 3-cycle glitch on START gives no pulse. START held 10 cycles → exactly one `key0`, 7 edges after the press; `en` rises the same edge.
- **Preset and down count:** SET, then SET×2 → `ten`=2; MODE, then SET×13 → `one`=3; MODE → IDLE; MODE → `dir_down`=1; START → `key1` pulse, RUN_DOWN. Then `cnt_zero`=1 → DONE, `done_led`=1, `en`=0.
- **Pause and abort:** START/START in RUN_UP → one `key4` pulse each, `pause` 1 then 0. Pause again, then MODE → IDLE, `en`=0.
- **Simultaneous events:** START and SET pressed together in IDLE → RUN_UP only, `ten`/`one` unchanged. START and `cnt_zero` in the same cycle in RUN_DOWN → DONE, no `key4`.
- **Boundaries:** dir down with preset 00, START → stays IDLE, no `key1`. `ten` wraps 5→0 and `one` wraps 9→0.
- **Reset mid-run:** `rst_n` low in PAUSED → all outputs 0 and `ten`=`one`=0 immediately. FREQ after release gives `key5` in IDLE.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer front-panel controller.
// Holds the mode-FSM state encoding, the button index map used to pick
// bits out of the 4-bit key bus, the BCD preset limits and a small BCD
// increment helper used by the preset registers.
package timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_TEN  = 3'd1,
        ST_SET_ONE  = 3'd2,
        ST_RUN_UP   = 3'd3,
        ST_RUN_DOWN = 3'd4,
        ST_PAUSED   = 3'd5,
        ST_DONE     = 3'd6
    } ctrl_state_t;

    localparam int KEY_START = 0;
    localparam int KEY_MODE  = 1;
    localparam int KEY_SET   = 2;
    localparam int KEY_FREQ  = 3;

    localparam logic [3:0] TEN_MAX = 4'd5;
    localparam logic [3:0] ONE_MAX = 4'd9;

    // Step a BCD digit, rolling over to zero once the limit is reached.
    function automatic logic [3:0] bcd_inc(input logic [3:0] val, input logic [3:0] max);
        return (val >= max) ? 4'd0 : val + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single push-button conditioner.
// A raw active-low button is passed through a 2-FF synchroniser, then a
// debounce counter that only accepts a level change after DEBOUNCE_CYCLES
// consecutive samples that disagree with the current stable level.
// A 1-cycle registered pulse is emitted when the stable level falls
// (press); releases are accepted silently.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   key_raw  in  raw button level, 0 = pressed
//   press    out 1-cycle press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // sync_q[1] is the synchronised level. The counter runs only while it
    // disagrees with the stable level; the sample that completes the run
    // flips the stable level in the same edge, so a press pulse appears
    // DEBOUNCE_CYCLES edges after the synchronised level first drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
            press  <= 1'b0;
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q[1];
                cnt    <= '0;
                press  <= ~sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_key_ctrl.sv
// Front-panel controller for the 60 s timer datapath.
// Debounces the four panel buttons and runs the mode FSM that sequences
// the timer core (enable, pause, start/pause pulses) and holds the BCD
// down-count preset. All outputs come straight from flops.
// Ports:
//   clk_50M   in  system clock
//   rst_n     in  asynchronous active-low reset
//   key_raw   in  raw buttons, active-low: [0] START [1] MODE [2] SET [3] FREQ
//   cnt_zero  in  core reports 00.0 while counting down
//   en, pause out timer enable / pause levels
//   key0/1/4/5 out 1-cycle pulses: count-up, count-down, pause toggle, freq step
//   ten, one  out BCD preset digits
//   dir_down  out selected direction (1 = down)
//   done_led  out high in DONE
//   state_o   out current FSM state, for debug
module timer_key_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [3:0] key_raw,
    input  logic       cnt_zero,
    output logic       en,
    output logic       pause,
    output logic       key0,
    output logic       key1,
    output logic       key4,
    output logic       key5,
    output logic [3:0] ten,
    output logic [3:0] one,
    output logic       dir_down,
    output logic       done_led,
    output logic [2:0] state_o
);

    logic [3:0]  press;
    ctrl_state_t state, state_nx;
    logic        dir_nx, resume_down, resume_down_nx;
    logic [3:0]  ten_nx, one_nx;
    logic        key0_nx, key1_nx, key4_nx;
    logic        start_ev, mode_ev, set_ev;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk_50M),
            .rst_n  (rst_n),
            .key_raw(key_raw[g]),
            .press  (press[g])
        );
    end

    // Only one FSM event per cycle: START beats MODE beats SET.
    assign start_ev = press[KEY_START];
    assign mode_ev  = press[KEY_MODE] & ~press[KEY_START];
    assign set_ev   = press[KEY_SET] & ~press[KEY_START] & ~press[KEY_MODE];

    // Next-state, preset and pulse decisions.
    always_comb begin
        state_nx       = state;
        dir_nx         = dir_down;
        ten_nx         = ten;
        one_nx         = one;
        resume_down_nx = resume_down;
        key0_nx        = 1'b0;
        key1_nx        = 1'b0;
        key4_nx        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ev) begin
                    if (!dir_down) begin
                        state_nx = ST_RUN_UP;
                        key0_nx  = 1'b1;
                    end else if ((ten != 4'd0) || (one != 4'd0)) begin
                        // A down-count from 00 would finish instantly, so it is refused.
                        state_nx = ST_RUN_DOWN;
                        key1_nx  = 1'b1;
                    end
                end else if (mode_ev) begin
                    dir_nx = ~dir_down;
                end else if (set_ev) begin
                    state_nx = ST_SET_TEN;
                end
            end
            ST_SET_TEN: begin
                if (start_ev)     state_nx = ST_IDLE;
                else if (mode_ev) state_nx = ST_SET_ONE;
                else if (set_ev)  ten_nx   = bcd_inc(ten, TEN_MAX);
            end
            ST_SET_ONE: begin
                if (start_ev || mode_ev) state_nx = ST_IDLE;
                else if (set_ev)         one_nx   = bcd_inc(one, ONE_MAX);
            end
            ST_RUN_UP: begin
                if (start_ev) begin
                    state_nx       = ST_PAUSED;
                    key4_nx        = 1'b1;
                    resume_down_nx = 1'b0;
                end
            end
            ST_RUN_DOWN: begin
                // Reaching zero wins over a pause request in the same cycle.
                if (cnt_zero) begin
                    state_nx = ST_DONE;
                end else if (start_ev) begin
                    state_nx       = ST_PAUSED;
                    key4_nx        = 1'b1;
                    resume_down_nx = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (start_ev) begin
                    state_nx = resume_down ? ST_RUN_DOWN : ST_RUN_UP;
                    key4_nx  = 1'b1;
                end else if (mode_ev) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (start_ev || mode_ev) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and output registers; level outputs are decoded from the next
    // state so they change on the same edge as the matching pulse.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dir_down    <= 1'b0;
            ten         <= 4'd0;
            one         <= 4'd0;
            resume_down <= 1'b0;
            key0        <= 1'b0;
            key1        <= 1'b0;
            key4        <= 1'b0;
            key5        <= 1'b0;
            en          <= 1'b0;
            pause       <= 1'b0;
            done_led    <= 1'b0;
        end else begin
            state       <= state_nx;
            dir_down    <= dir_nx;
            ten         <= ten_nx;
            one         <= one_nx;
            resume_down <= resume_down_nx;
            key0        <= key0_nx;
            key1        <= key1_nx;
            key4        <= key4_nx;
            key5        <= press[KEY_FREQ];
            en          <= (state_nx == ST_RUN_UP) || (state_nx == ST_RUN_DOWN) ||
                           (state_nx == ST_PAUSED);
            pause       <= (state_nx == ST_PAUSED);
            done_led    <= (state_nx == ST_DONE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Directed self-checking bench for timer_key_ctrl with DEBOUNCE_CYCLES = 4.
// Buttons are pressed via press_mask; a negedge monitor counts output
// pulses and records the cycle they appeared on so latency can be checked.
module tb_timer_key_ctrl;

    localparam int K_START = 0;
    localparam int K_MODE  = 1;
    localparam int K_SET   = 2;
    localparam int K_FREQ  = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SET_TEN  = 3'd1;
    localparam logic [2:0] S_SET_ONE  = 3'd2;
    localparam logic [2:0] S_RUN_UP   = 3'd3;
    localparam logic [2:0] S_RUN_DOWN = 3'd4;
    localparam logic [2:0] S_PAUSED   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic       clk_50M;
    logic       rst_n;
    logic [3:0] key_raw;
    logic       cnt_zero;
    logic       en, pause, key0, key1, key4, key5, dir_down, done_led;
    logic [3:0] ten, one;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int press_cyc = 0;
    int key0_cnt = 0, key1_cnt = 0, key4_cnt = 0, key5_cnt = 0;
    int key0_cyc = 0, key5_cyc = 0;
    logic key0_en = 1'b0;

    timer_key_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .key_raw (key_raw),
        .cnt_zero(cnt_zero),
        .en      (en),
        .pause   (pause),
        .key0    (key0),
        .key1    (key1),
        .key4    (key4),
        .key5    (key5),
        .ten     (ten),
        .one     (one),
        .dir_down(dir_down),
        .done_led(done_led),
        .state_o (state_o)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    always @(negedge clk_50M) begin
        if (key0 === 1'b1) begin
            key0_cnt <= key0_cnt + 1;
            key0_cyc <= cyc;
            key0_en  <= en;
        end
        if (key1 === 1'b1) key1_cnt <= key1_cnt + 1;
        if (key4 === 1'b1) key4_cnt <= key4_cnt + 1;
        if (key5 === 1'b1) begin
            key5_cnt <= key5_cnt + 1;
            key5_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Hold the masked buttons low for 'hold' edges, then release and wait
    // long enough for the release to debounce.
    task automatic press_mask(input logic [3:0] mask, input int hold);
        @(posedge clk_50M); #1;
        key_raw   = ~mask;
        press_cyc = cyc;
        repeat (hold) @(posedge clk_50M);
        #1;
        key_raw = 4'hF;
        repeat (8) @(posedge clk_50M);
        #1;
    endtask

    task automatic press(input int idx);
        logic [3:0] m;
        m = 4'h0;
        m[idx] = 1'b1;
        press_mask(m, 6);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; key_raw = 4'hF; cnt_zero = 1'b0;
        repeat (3) @(posedge clk_50M);
        #2;
        if ({en, pause, key0, key1, key4, key5, done_led, dir_down} !== 8'h00) begin
            $display("[TB] FAIL reset_levels: got %b, expected 00000000",
                     {en, pause, key0, key1, key4, key5, done_led, dir_down}); n_fail++; end
        n_tests++;
        if ({ten, one} !== 8'h00) begin
            $display("[TB] FAIL reset_preset: got %h, expected 00", {ten, one}); n_fail++; end
        n_tests++;
        if (state_o !== S_IDLE) begin
            $display("[TB] FAIL reset_state: got %0d, expected %0d", state_o, S_IDLE); n_fail++; end
        n_tests++;
        @(negedge clk_50M) rst_n = 1'b1;
        repeat (3) @(posedge clk_50M);
    endtask

    task automatic test_debounce;
        int k0;
        k0 = key0_cnt;
        press_mask(4'b0001, 3);
        if (key0_cnt - k0 !== 0) begin
            $display("[TB] FAIL glitch_key0: got %0d, expected 0", key0_cnt - k0); n_fail++; end
        n_tests++;
        if (state_o !== S_IDLE) begin
            $display("[TB] FAIL glitch_state: got %0d, expected %0d", state_o, S_IDLE); n_fail++; end
        n_tests++;
        press_mask(4'b0001, 10);
        if (key0_cnt - k0 !== 1) begin
            $display("[TB] FAIL hold_key0_count: got %0d, expected 1", key0_cnt - k0); n_fail++; end
        n_tests++;
        if (key0_cyc - press_cyc !== 7) begin
            $display("[TB] FAIL key0_latency: got %0d, expected 7", key0_cyc - press_cyc); n_fail++; end
        n_tests++;
        if (key0_en !== 1'b1) begin
            $display("[TB] FAIL en_with_key0: got %b, expected 1", key0_en); n_fail++; end
        n_tests++;
        if (state_o !== S_RUN_UP) begin
            $display("[TB] FAIL run_up_state: got %0d, expected %0d", state_o, S_RUN_UP); n_fail++; end
        n_tests++;
    endtask

    task automatic test_pause_abort;
        int k4;
        k4 = key4_cnt;
        press(K_START);
        if ({state_o, pause, en} !== {S_PAUSED, 2'b11}) begin
            $display("[TB] FAIL pause1: got state %0d pause %b en %b, expected 5 1 1",
                     state_o, pause, en); n_fail++; end
        n_tests++;
        if (key4_cnt - k4 !== 1) begin
            $display("[TB] FAIL pause1_key4: got %0d, expected 1", key4_cnt - k4); n_fail++; end
        n_tests++;
        press(K_START);
        if ({state_o, pause, en} !== {S_RUN_UP, 2'b01}) begin
            $display("[TB] FAIL resume: got state %0d pause %b en %b, expected 3 0 1",
                     state_o, pause, en); n_fail++; end
        n_tests++;
        if (key4_cnt - k4 !== 2) begin
            $display("[TB] FAIL resume_key4: got %0d, expected 2", key4_cnt - k4); n_fail++; end
        n_tests++;
        press(K_START);
        press(K_MODE);
        if ({state_o, pause, en} !== {S_IDLE, 2'b00}) begin
            $display("[TB] FAIL abort: got state %0d pause %b en %b, expected 0 0 0",
                     state_o, pause, en); n_fail++; end
        n_tests++;
    endtask

    task automatic test_zero_preset;
        int k1;
        k1 = key1_cnt;
        press(K_MODE);
        if (dir_down !== 1'b1) begin
            $display("[TB] FAIL dir_toggle: got %b, expected 1", dir_down); n_fail++; end
        n_tests++;
        press(K_START);
        if (state_o !== S_IDLE || key1_cnt - k1 !== 0) begin
            $display("[TB] FAIL zero_preset_start: got state %0d key1 %0d, expected 0 0",
                     state_o, key1_cnt - k1); n_fail++; end
        n_tests++;
        press(K_MODE);
        if (dir_down !== 1'b0) begin
            $display("[TB] FAIL dir_back: got %b, expected 0", dir_down); n_fail++; end
        n_tests++;
    endtask

    task automatic test_preset_down;
        int k1;
        press(K_SET);
        if (state_o !== S_SET_TEN) begin
            $display("[TB] FAIL enter_set_ten: got %0d, expected %0d", state_o, S_SET_TEN); n_fail++; end
        n_tests++;
        for (int i = 0; i < 2; i++) press(K_SET);
        if (ten !== 4'd2) begin
            $display("[TB] FAIL ten_set: got %0d, expected 2", ten); n_fail++; end
        n_tests++;
        press(K_MODE);
        if (state_o !== S_SET_ONE) begin
            $display("[TB] FAIL enter_set_one: got %0d, expected %0d", state_o, S_SET_ONE); n_fail++; end
        n_tests++;
        for (int i = 0; i < 13; i++) press(K_SET);
        if (one !== 4'd3) begin
            $display("[TB] FAIL one_set: got %0d, expected 3", one); n_fail++; end
        n_tests++;
        press(K_MODE);
        press(K_MODE);
        if (state_o !== S_IDLE || dir_down !== 1'b1) begin
            $display("[TB] FAIL idle_dir_down: got state %0d dir %b, expected 0 1",
                     state_o, dir_down); n_fail++; end
        n_tests++;
        k1 = key1_cnt;
        press(K_START);
        if (state_o !== S_RUN_DOWN || key1_cnt - k1 !== 1) begin
            $display("[TB] FAIL run_down: got state %0d key1 %0d, expected 4 1",
                     state_o, key1_cnt - k1); n_fail++; end
        n_tests++;
        @(posedge clk_50M); #1; cnt_zero = 1'b1;
        @(posedge clk_50M); #1; cnt_zero = 1'b0;
        if ({state_o, done_led, en} !== {S_DONE, 2'b10}) begin
            $display("[TB] FAIL done: got state %0d led %b en %b, expected 6 1 0",
                     state_o, done_led, en); n_fail++; end
        n_tests++;
        press(K_MODE);
        if (state_o !== S_IDLE || done_led !== 1'b0) begin
            $display("[TB] FAIL done_exit: got state %0d led %b, expected 0 0",
                     state_o, done_led); n_fail++; end
        n_tests++;
    endtask

    task automatic test_wrap;
        press(K_SET);
        for (int i = 0; i < 3; i++) press(K_SET);
        if (ten !== 4'd5) begin
            $display("[TB] FAIL ten_max: got %0d, expected 5", ten); n_fail++; end
        n_tests++;
        press(K_SET);
        if (ten !== 4'd0) begin
            $display("[TB] FAIL ten_wrap: got %0d, expected 0", ten); n_fail++; end
        n_tests++;
        press(K_SET);
        press(K_MODE);
        for (int i = 0; i < 6; i++) press(K_SET);
        if (one !== 4'd9) begin
            $display("[TB] FAIL one_max: got %0d, expected 9", one); n_fail++; end
        n_tests++;
        press(K_SET);
        if (one !== 4'd0) begin
            $display("[TB] FAIL one_wrap: got %0d, expected 0", one); n_fail++; end
        n_tests++;
        press(K_SET);
        press(K_START);
        if (state_o !== S_IDLE || {ten, one} !== 8'h11) begin
            $display("[TB] FAIL set_exit: got state %0d preset %h, expected 0 11",
                     state_o, {ten, one}); n_fail++; end
        n_tests++;
    endtask

    task automatic test_simultaneous;
        int k0, k4;
        press(K_MODE);
        k0 = key0_cnt;
        press_mask(4'b0101, 6);
        if (state_o !== S_RUN_UP || key0_cnt - k0 !== 1) begin
            $display("[TB] FAIL start_set_run: got state %0d key0 %0d, expected 3 1",
                     state_o, key0_cnt - k0); n_fail++; end
        n_tests++;
        if ({ten, one} !== 8'h11) begin
            $display("[TB] FAIL start_set_preset: got %h, expected 11", {ten, one}); n_fail++; end
        n_tests++;
        press(K_START);
        press(K_MODE);
        press(K_MODE);
        press(K_START);
        if (state_o !== S_RUN_DOWN) begin
            $display("[TB] FAIL run_down2: got %0d, expected %0d", state_o, S_RUN_DOWN); n_fail++; end
        n_tests++;
        k4 = key4_cnt;
        @(posedge clk_50M); #1;
        key_raw[K_START] = 1'b0;
        repeat (6) @(posedge clk_50M);
        #1;
        cnt_zero = 1'b1;
        key_raw  = 4'hF;
        @(posedge clk_50M); #1;
        cnt_zero = 1'b0;
        repeat (8) @(posedge clk_50M);
        #1;
        if (state_o !== S_DONE || key4_cnt - k4 !== 0) begin
            $display("[TB] FAIL zero_beats_start: got state %0d key4 %0d, expected 6 0",
                     state_o, key4_cnt - k4); n_fail++; end
        n_tests++;
        press(K_START);
        if (state_o !== S_IDLE) begin
            $display("[TB] FAIL done_start_exit: got %0d, expected %0d", state_o, S_IDLE); n_fail++; end
        n_tests++;
    endtask

    task automatic test_reset_mid_run;
        int k5;
        press(K_START);
        press(K_START);
        if (state_o !== S_PAUSED || pause !== 1'b1) begin
            $display("[TB] FAIL pre_reset_paused: got state %0d pause %b, expected 5 1",
                     state_o, pause); n_fail++; end
        n_tests++;
        @(posedge clk_50M); #3;
        rst_n = 1'b0;
        #1;
        if ({en, pause, key0, key1, key4, key5, done_led, dir_down} !== 8'h00) begin
            $display("[TB] FAIL async_reset_levels: got %b, expected 00000000",
                     {en, pause, key0, key1, key4, key5, done_led, dir_down}); n_fail++; end
        n_tests++;
        if ({ten, one} !== 8'h00 || state_o !== S_IDLE) begin
            $display("[TB] FAIL async_reset_preset: got preset %h state %0d, expected 00 0",
                     {ten, one}, state_o); n_fail++; end
        n_tests++;
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M) rst_n = 1'b1;
        k5 = key5_cnt;
        press(K_FREQ);
        if (key5_cnt - k5 !== 1 || key5_cyc - press_cyc !== 7) begin
            $display("[TB] FAIL freq_after_reset: got count %0d latency %0d, expected 1 7",
                     key5_cnt - k5, key5_cyc - press_cyc); n_fail++; end
        n_tests++;
        if (state_o !== S_IDLE) begin
            $display("[TB] FAIL freq_state: got %0d, expected %0d", state_o, S_IDLE); n_fail++; end
        n_tests++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_pause_abort();
        test_zero_preset();
        test_preset_down();
        test_wrap();
        test_simultaneous();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
